data_bus_bridge: RTL and testbench

//  Downstream of the single-cycle RV32 core's data port: converts core stores (WR size code, D_OUT,
//  D_OUT_ADDR) into byte-laned word writes via a DEPTH-entry posted store buffer, and core loads
//  (RD, D_IN_ADDR) into word reads. Drives a req/grant + rvalid memory bus and stalls the core
//  (STALL) while a load is outstanding or the buffer is full. Returns whole words; the core's trim logic extracts bytes/halves.

---
 rtl/data_bus_bridge.sv | 207 ++++++++++++++++++++
 tb/tb_data_bus_bridge.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_bus_bridge.sv
// data_bus_bridge
//   Sits between the RV32 core's data port and a req/grant + rvalid memory bus.
//   Core stores are turned into byte-laned word writes and posted into a
//   DEPTH-entry FIFO that drains in the background. Core loads become word
//   reads. A load first waits for every buffered store to drain, so a load
//   never overtakes an earlier store. D_IN always returns the whole word.
//
// Ports
//   CLK, RST              clock (rising edge), asynchronous active-low reset
//   WR[1:0]               store size: 00 none, 01 byte, 10 half, 11 word
//   RD                    load request, held by the core while STALL=1
//   D_OUT, D_OUT_ADDR     store data (LSB-aligned) and store byte address
//   D_IN_ADDR             load byte address
//   D_IN                  load word, valid when RD=1 and STALL=0
//   STALL                 core must hold its PC and all inputs
//   ERR                   one-cycle pulse: misaligned store, RD&WR together, read timeout
//   BUF_EMPTY             store buffer holds no entries
//   M_REQ, M_WE, M_ADDR,
//   M_BE, M_WDATA         bus request, direction, word address, byte enables, write data
//   M_GNT                 transfer accepted at a rising edge where M_REQ&M_GNT
//   M_RVALID, M_RDATA     read data return
`timescale 1ns/1ps

module data_bus_bridge #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned RD_TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [1:0]  WR,
  input  logic        RD,
  input  logic [31:0] D_OUT,
  input  logic [31:0] D_OUT_ADDR,
  input  logic [31:0] D_IN_ADDR,
  output logic [31:0] D_IN,
  output logic        STALL,
  output logic        ERR,
  output logic        BUF_EMPTY,
  output logic        M_REQ,
  output logic        M_WE,
  output logic [31:0] M_ADDR,
  output logic [3:0]  M_BE,
  output logic [31:0] M_WDATA,
  input  logic        M_GNT,
  input  logic        M_RVALID,
  input  logic [31:0] M_RDATA
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = $clog2(RD_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, DRAIN, RD_REQ, RD_WAIT, RD_DONE} state_t;

  state_t        state;
  logic [29:0]   buf_addr [DEPTH];
  logic [3:0]    buf_be   [DEPTH];
  logic [31:0]   buf_data [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [TW-1:0] timer;

  logic        is_store;
  logic        misaligned;
  logic        full;
  logic        empty;
  logic        conflict;
  logic        draining;
  logic        rd_issue;
  logic        push;
  logic        pop;
  logic [3:0]  st_be;
  logic [31:0] st_data;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^D_IN_ADDR[1:0];

  assign is_store   = (WR != 2'b00);
  assign misaligned = ((WR == 2'b10) && D_OUT_ADDR[0]) ||
                      ((WR == 2'b11) && (D_OUT_ADDR[1:0] != 2'b00));
  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign conflict   = RD && is_store && (state == IDLE);
  assign draining   = !empty && ((state == IDLE) || (state == DRAIN));
  // A load seen in IDLE with nothing buffered is put on the bus in that same
  // cycle, so an immediate grant gives the 3-cycle REQ/WAIT/DONE load.
  assign rd_issue   = (state == RD_REQ) ||
                      ((state == IDLE) && RD && !is_store && empty);
  assign push       = is_store && !RD && !misaligned && !full;
  assign pop        = draining && M_GNT;
  assign count_next = count + CW'(push) - CW'(pop);

  assign BUF_EMPTY  = empty;
  assign STALL      = RST && !conflict &&
                      ((RD && (state != RD_DONE)) ||
                       (is_store && !RD && full && !misaligned));

  // Lane placement of the store data.
  always_comb begin
    st_be   = '0;
    st_data = '0;
    case (WR)
      2'b01: begin
        st_be   = 4'b0001 << D_OUT_ADDR[1:0];
        st_data = {4{D_OUT[7:0]}};
      end
      2'b10: begin
        st_be   = D_OUT_ADDR[1] ? 4'b1100 : 4'b0011;
        st_data = {2{D_OUT[15:0]}};
      end
      2'b11: begin
        st_be   = 4'b1111;
        st_data = D_OUT;
      end
      default: ;
    endcase
  end

  // Bus side: the buffer head has priority; a read is only issued once empty.
  always_comb begin
    M_REQ   = 1'b0;
    M_WE    = 1'b0;
    M_ADDR  = '0;
    M_BE    = '0;
    M_WDATA = '0;
    if (RST && draining) begin
      M_REQ   = 1'b1;
      M_WE    = 1'b1;
      M_ADDR  = {buf_addr[rd_ptr], 2'b00};
      M_BE    = buf_be[rd_ptr];
      M_WDATA = buf_data[rd_ptr];
    end else if (RST && rd_issue) begin
      M_REQ   = 1'b1;
      M_ADDR  = {D_IN_ADDR[31:2], 2'b00};
      M_BE    = 4'b1111;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      buf_addr[wr_ptr] <= D_OUT_ADDR[31:2];
      buf_be[wr_ptr]   <= st_be;
      buf_data[wr_ptr] <= st_data;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      timer  <= '0;
      ERR    <= 1'b0;
      D_IN   <= '0;
    end else begin
      ERR   <= 1'b0;
      count <= count_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (is_store && !RD && misaligned) ERR <= 1'b1;

      case (state)
        IDLE: begin
          if (conflict) begin
            ERR <= 1'b1;
          end else if (RD) begin
            if (count_next != '0) begin
              state <= DRAIN;
            end else if (rd_issue && M_GNT) begin
              state <= RD_WAIT;
              timer <= '0;
            end else begin
              state <= RD_REQ;
            end
          end
        end
        DRAIN: begin
          if (count_next == '0) state <= RD_REQ;
        end
        RD_REQ: begin
          if (M_GNT) begin
            state <= RD_WAIT;
            timer <= '0;
          end
        end
        RD_WAIT: begin
          if (M_RVALID) begin
            D_IN  <= M_RDATA;
            state <= RD_DONE;
          end else if (timer == TW'(RD_TIMEOUT)) begin
            D_IN  <= 32'hDEADBEEF;
            ERR   <= 1'b1;
            state <= RD_DONE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RD_DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_bus_bridge.sv
// tb_data_bus_bridge
//   Self-checking bench for data_bus_bridge. Store lane placement is covered
//   by a table of vectors; multi-cycle behaviour (full buffer, load ordering,
//   load latency, read timeout, RD/WR conflict, mid-transfer reset) by short
//   hand-written sequences. Every expected bus transfer is queued when its
//   stimulus is driven and compared when the bus accepts a transfer.
`timescale 1ns/1ps

module tb_data_bus_bridge;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  WR;
  logic        RD;
  logic [31:0] D_OUT;
  logic [31:0] D_OUT_ADDR;
  logic [31:0] D_IN_ADDR;
  logic [31:0] D_IN;
  logic        STALL;
  logic        ERR;
  logic        BUF_EMPTY;
  logic        M_REQ;
  logic        M_WE;
  logic [31:0] M_ADDR;
  logic [3:0]  M_BE;
  logic [31:0] M_WDATA;
  logic        M_GNT;
  logic        M_RVALID;
  logic [31:0] M_RDATA;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } xfer_t;

  typedef struct {
    logic [1:0]  wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        err;
  } vec_t;

  xfer_t       exp_q[$];
  vec_t        vecs[9];
  int          tests = 0;
  int          fails = 0;
  bit          rd_armed;
  bit          rvalid_on;
  logic [31:0] rdata_val;
  int          n;

  data_bus_bridge #(.DEPTH(4), .RD_TIMEOUT(255)) dut (
    .CLK(CLK), .RST(RST), .WR(WR), .RD(RD), .D_OUT(D_OUT),
    .D_OUT_ADDR(D_OUT_ADDR), .D_IN_ADDR(D_IN_ADDR), .D_IN(D_IN),
    .STALL(STALL), .ERR(ERR), .BUF_EMPTY(BUF_EMPTY), .M_REQ(M_REQ),
    .M_WE(M_WE), .M_ADDR(M_ADDR), .M_BE(M_BE), .M_WDATA(M_WDATA),
    .M_GNT(M_GNT), .M_RVALID(M_RVALID), .M_RDATA(M_RDATA)
  );

  always #5 CLK = ~CLK;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wdata);
    exp_q.push_back(xfer_t'{1'b1, addr, be, wdata});
  endtask

  task automatic push_rd(input logic [31:0] addr);
    exp_q.push_back(xfer_t'{1'b0, addr, 4'b1111, 32'h0});
  endtask

  // One clock: inspect the bus at the falling edge (the transfer completes at
  // the next rising edge), then act as the memory's read-data return.
  task automatic step();
    xfer_t e;
    @(negedge CLK);
    if (M_REQ === 1'b1 && M_GNT === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL bus_unexpected: got we=%0b addr=0x%08h be=%b, expected no transfer",
                 M_WE, M_ADDR, M_BE);
      end else begin
        e = exp_q.pop_front();
        check32("bus_we", 32'(M_WE), 32'(e.we));
        check32("bus_addr", M_ADDR, e.addr);
        check32("bus_be", 32'(M_BE), 32'(e.be));
        if (e.we) check32("bus_wdata", M_WDATA, e.wdata);
      end
      if (M_WE === 1'b0) rd_armed = 1'b1;
    end
    @(posedge CLK);
    #1;
    M_RVALID = 1'b0;
    if (rd_armed && rvalid_on) begin
      M_RVALID  = 1'b1;
      M_RDATA   = rdata_val;
      rd_armed  = 1'b0;
    end
  endtask

  task automatic wait_unstall(input int limit, output int cnt);
    cnt = 0;
    #1;
    while (STALL === 1'b1 && cnt < limit) begin
      step();
      cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{2'b01, 32'h0000_0103, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5, 1'b0};
    vecs[1] = '{2'b01, 32'h0000_0100, 32'h1234_5677, 4'b0001, 32'h7777_7777, 1'b0};
    vecs[2] = '{2'b10, 32'h0000_0202, 32'hFFFF_BEEF, 4'b1100, 32'hBEEF_BEEF, 1'b0};
    vecs[3] = '{2'b10, 32'h0000_0200, 32'h0000_1234, 4'b0011, 32'h1234_1234, 1'b0};
    vecs[4] = '{2'b11, 32'h0000_0304, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 1'b0};
    vecs[5] = '{2'b10, 32'h0000_0201, 32'h0000_5555, 4'b0000, 32'h0,         1'b1};
    vecs[6] = '{2'b11, 32'h0000_0302, 32'h1111_1111, 4'b0000, 32'h0,         1'b1};
    vecs[7] = '{2'b11, 32'h0000_0301, 32'h2222_2222, 4'b0000, 32'h0,         1'b1};
    vecs[8] = '{2'b01, 32'h0000_03FE, 32'h0000_005A, 4'b0100, 32'h5A5A_5A5A, 1'b0};

    RST = 1'b0; WR = 2'b00; RD = 1'b0; D_OUT = '0; D_OUT_ADDR = '0; D_IN_ADDR = '0;
    M_GNT = 1'b0; M_RVALID = 1'b0; M_RDATA = '0;
    rd_armed = 1'b0; rvalid_on = 1'b1; rdata_val = '0;
    step();
    step();

    // Reset state.
    check32("rst_m_req", 32'(M_REQ), 32'd0);
    check32("rst_stall", 32'(STALL), 32'd0);
    check32("rst_err", 32'(ERR), 32'd0);
    check32("rst_buf_empty", 32'(BUF_EMPTY), 32'd1);
    check32("rst_d_in", D_IN, 32'h0);
    check32("rst_m_addr", M_ADDR, 32'h0);
    check32("rst_m_be", 32'(M_BE), 32'h0);
    check32("rst_m_wdata", M_WDATA, 32'h0);
    RST = 1'b1;
    step();

    // Store lane placement and misaligned rejection, bus always granting.
    M_GNT = 1'b1;
    for (int i = 0; i < 9; i++) begin
      WR = vecs[i].wr;
      D_OUT_ADDR = vecs[i].addr;
      D_OUT = vecs[i].data;
      if (!vecs[i].err) push_wr({vecs[i].addr[31:2], 2'b00}, vecs[i].be, vecs[i].wdata);
      #1;
      check32($sformatf("vec%0d_stall", i), 32'(STALL), 32'd0);
      step();
      WR = 2'b00;
      #1;
      check32($sformatf("vec%0d_err", i), 32'(ERR), 32'(vecs[i].err));
      check32($sformatf("vec%0d_buf_empty", i), 32'(BUF_EMPTY), 32'(vecs[i].err));
      step();
      check32($sformatf("vec%0d_drained", i), 32'(BUF_EMPTY), 32'd1);
      check32($sformatf("vec%0d_err_gone", i), 32'(ERR), 32'd0);
    end

    // Fill the buffer with the bus stalled, then a fifth store must wait.
    M_GNT = 1'b0;
    for (int i = 0; i < 4; i++) begin
      WR = 2'b11;
      D_OUT_ADDR = 32'h400 + 32'(4 * i);
      D_OUT = 32'hB000_0000 + 32'(i);
      push_wr(D_OUT_ADDR, 4'b1111, D_OUT);
      #1;
      check32($sformatf("fill%0d_stall", i), 32'(STALL), 32'd0);
      step();
    end
    D_OUT_ADDR = 32'h410;
    D_OUT = 32'hB000_0004;
    #1;
    check32("full_buf_empty", 32'(BUF_EMPTY), 32'd0);
    check32("full_stall", 32'(STALL), 32'd1);
    step();
    check32("full_still_stall", 32'(STALL), 32'd1);
    M_GNT = 1'b1;
    wait_unstall(10, n);
    check32("full_unstall", 32'(STALL), 32'd0);
    check32("full_unstall_cycles", 32'(n), 32'd1);
    push_wr(32'h410, 4'b1111, 32'hB000_0004);
    step();
    WR = 2'b00;
    for (int k = 0; k < 10 && BUF_EMPTY !== 1'b1; k++) step();
    check32("full_drained", 32'(BUF_EMPTY), 32'd1);
    check32("full_order_all_seen", 32'(exp_q.size()), 32'd0);

    // Load behind two buffered stores: both writes go first.
    M_GNT = 1'b0;
    for (int i = 0; i < 2; i++) begin
      WR = 2'b11;
      D_OUT_ADDR = 32'h500 + 32'(4 * i);
      D_OUT = 32'hC000_0000 + 32'(i);
      push_wr(D_OUT_ADDR, 4'b1111, D_OUT);
      step();
    end
    WR = 2'b00;
    RD = 1'b1;
    D_IN_ADDR = 32'h203;
    push_rd(32'h200);
    rdata_val = 32'h1234_5678;
    #1;
    check32("ld_order_stall", 32'(STALL), 32'd1);
    check32("ld_order_write_first", 32'(M_WE), 32'd1);
    step();
    M_GNT = 1'b1;
    wait_unstall(20, n);
    check32("ld_order_unstall", 32'(STALL), 32'd0);
    check32("ld_order_d_in", D_IN, 32'h1234_5678);
    check32("ld_order_err", 32'(ERR), 32'd0);
    RD = 1'b0;
    step();
    check32("ld_order_all_seen", 32'(exp_q.size()), 32'd0);

    // Minimum load latency with an empty buffer.
    RD = 1'b1;
    D_IN_ADDR = 32'h600;
    push_rd(32'h600);
    rdata_val = 32'hA1B2_C3D4;
    #1;
    check32("ld_min_req", 32'(M_REQ), 32'd1);
    check32("ld_min_we", 32'(M_WE), 32'd0);
    check32("ld_min_be", 32'(M_BE), 32'hF);
    wait_unstall(20, n);
    check32("ld_min_cycles", 32'(n), 32'd2);
    check32("ld_min_d_in", D_IN, 32'hA1B2_C3D4);
    RD = 1'b0;
    step();

    // Read whose data never returns.
    rvalid_on = 1'b0;
    RD = 1'b1;
    D_IN_ADDR = 32'h700;
    push_rd(32'h700);
    wait_unstall(400, n);
    check32("tmo_cycles", 32'(n), 32'd257);
    check32("tmo_stall", 32'(STALL), 32'd0);
    check32("tmo_d_in", D_IN, 32'hDEAD_BEEF);
    check32("tmo_err", 32'(ERR), 32'd1);
    RD = 1'b0;
    rd_armed = 1'b0;
    rvalid_on = 1'b1;
    step();
    check32("tmo_err_pulse", 32'(ERR), 32'd0);
    check32("tmo_stall_after", 32'(STALL), 32'd0);

    // RD and WR together: error, nothing performed, no stall.
    WR = 2'b11;
    D_OUT_ADDR = 32'h800;
    D_OUT = 32'h0F0F_0F0F;
    RD = 1'b1;
    D_IN_ADDR = 32'h800;
    #1;
    check32("conf_stall", 32'(STALL), 32'd0);
    check32("conf_m_req", 32'(M_REQ), 32'd0);
    step();
    check32("conf_err", 32'(ERR), 32'd1);
    check32("conf_buf_empty", 32'(BUF_EMPTY), 32'd1);
    WR = 2'b00;
    RD = 1'b0;
    step();
    check32("conf_err_pulse", 32'(ERR), 32'd0);

    // Reset while a load waits behind three buffered stores.
    M_GNT = 1'b0;
    for (int i = 0; i < 3; i++) begin
      WR = 2'b11;
      D_OUT_ADDR = 32'h900 + 32'(4 * i);
      D_OUT = 32'hD000_0000 + 32'(i);
      step();
    end
    WR = 2'b00;
    RD = 1'b1;
    D_IN_ADDR = 32'h980;
    step();
    #1;
    check32("mid_rst_pre_req", 32'(M_REQ), 32'd1);
    RST = 1'b0;
    #1;
    check32("mid_rst_m_req", 32'(M_REQ), 32'd0);
    check32("mid_rst_buf_empty", 32'(BUF_EMPTY), 32'd1);
    check32("mid_rst_stall", 32'(STALL), 32'd0);
    check32("mid_rst_d_in", D_IN, 32'h0);
    RD = 1'b0;
    step();
    RST = 1'b1;
    M_GNT = 1'b1;
    RD = 1'b1;
    push_rd(32'h980);
    rdata_val = 32'h0BAD_F00D;
    wait_unstall(20, n);
    check32("post_rst_ld_cycles", 32'(n), 32'd2);
    check32("post_rst_ld_d_in", D_IN, 32'h0BAD_F00D);
    RD = 1'b0;
    step();
    step();
    check32("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
